// File: rtl/eq_gain_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : eq_gain_loader_if
// Description : Link between the gain loader and the equalizer gain block.
//               Carries the EQ frame status into the loader and the gain RAM
//               write port out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface eq_gain_loader_if;
  // EQ status, driven by the gain block side
  logic       eq_run;
  logic       eq_frame_start;
  logic       eq_frame_done;
  logic       eq_wr_addr_zero;
  // gain RAM write port, driven by the loader
  logic       eq_wr;
  logic       eq_wr_rst;
  logic [7:0] eq_gain_lsb;
  logic [7:0] eq_gain_msb;

  modport master (
    input  eq_run,
    input  eq_frame_start,
    input  eq_frame_done,
    input  eq_wr_addr_zero,
    output eq_wr,
    output eq_wr_rst,
    output eq_gain_lsb,
    output eq_gain_msb
  );

  modport slave (
    output eq_run,
    output eq_frame_start,
    output eq_frame_done,
    output eq_wr_addr_zero,
    input  eq_wr,
    input  eq_wr_rst,
    input  eq_gain_lsb,
    input  eq_gain_msb
  );
endinterface
`default_nettype wire

// File: rtl/eq_gain_loader.sv
`default_nettype none
// ============================================================================
// Module      : eq_gain_loader
// Description : Sequencer for the equalizer gain RAM. Keeps a CPU-written
//               shadow table of per-filter gains and copies it into the gain
//               block in one burst, only in the idle window between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_gain_loader #(
  parameter int          NUM_FILTERS  = 4,
  parameter logic [15:0] DEFAULT_GAIN = 16'h4000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_wr,
  input  logic [3:0]       cpu_addr,
  input  logic             cpu_byte_hi,
  input  logic [7:0]       cpu_data,
  input  logic             cpu_commit,
  output logic             busy,
  output logic             commit_done,
  output logic             collision,
  output logic             addr_error,
  eq_gain_loader_if.master eq
);

  localparam int               IDX_W    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RST  = 3'd2,
    S_CHK  = 3'd3,
    S_WR   = 3'd4,
    S_GAP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         idx_next;
  logic                     pending;
  logic                     pending_next;
  logic                     clr_pending;
  logic                     set_addr_error;
  logic                     in_frame;
  logic                     window_open;
  logic                     load_active;
  logic [16*NUM_FILTERS-1:0] shadow_flat;
  logic [15:0]              sel_gain;
  logic                     wr_en;
  logic                     wr_rst;
  logic [7:0]               gain_lsb;
  logic [7:0]               gain_msb;

  // One shadow register per filter; addresses beyond the table match no entry
  for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_shadow
    logic [15:0] entry;

    // Byte-wide CPU update of this entry
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        entry <= DEFAULT_GAIN;
      end else if (cpu_wr && (cpu_addr == 4'(i))) begin
        if (cpu_byte_hi) begin
          entry[15:8] <= cpu_data;
        end else begin
          entry[7:0]  <= cpu_data;
        end
      end
    end

    assign shadow_flat[16*i +: 16] = entry;
  end

  // Pick the entry the next write will carry
  always_comb begin
    sel_gain = DEFAULT_GAIN;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        sel_gain = shadow_flat[16*i +: 16];
      end
    end
  end

  // A stopped EQ never computes samples, so the window is open regardless
  assign window_open = !eq.eq_run || (!in_frame && !eq.eq_frame_start);
  assign load_active = (state == S_RST) || (state == S_CHK) ||
                       (state == S_WR)  || (state == S_GAP);

  // Track whether the gain block is in the middle of a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame <= 1'b0;
    end else if (eq.eq_frame_start && eq.eq_run) begin
      in_frame <= 1'b1;
    end else if (eq.eq_frame_done || !eq.eq_run) begin
      in_frame <= 1'b0;
    end
  end

  // Next-state logic for the load sequence
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    clr_pending    = 1'b0;
    set_addr_error = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (window_open) begin
          state_next  = S_RST;
          clr_pending = 1'b1;
        end
      end
      S_RST: begin
        state_next = S_CHK;
      end
      S_CHK: begin
        if (eq.eq_wr_addr_zero) begin
          state_next = S_WR;
          idx_next   = '0;
        end else begin
          state_next     = S_IDLE;
          set_addr_error = 1'b1;
          clr_pending    = 1'b1;
        end
      end
      S_WR: begin
        state_next = S_GAP;
      end
      S_GAP: begin
        // gain block bumps its address the cycle after a write
        if (idx == LAST_IDX) begin
          state_next = S_DONE;
        end else begin
          state_next = S_WR;
          idx_next   = idx + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // a new request always wins, so commits during a load are never lost
    pending_next = cpu_commit ? 1'b1 : (clr_pending ? 1'b0 : pending);
  end

  // State, index and pending request registers; defaults load after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      pending <= 1'b1;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      pending <= pending_next;
    end
  end

  // Registered outputs follow the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      commit_done <= 1'b0;
      wr_en       <= 1'b0;
      wr_rst      <= 1'b0;
      gain_lsb    <= 8'h00;
      gain_msb    <= 8'h00;
    end else begin
      busy        <= pending_next || (state_next != S_IDLE);
      commit_done <= (state_next == S_DONE);
      wr_en       <= (state_next == S_WR);
      wr_rst      <= (state_next == S_RST);
      if (state_next == S_WR) begin
        gain_lsb <= sel_gain[7:0];
        gain_msb <= sel_gain[15:8];
      end
    end
  end

  // Sticky error flags, cleared by the next commit request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision  <= 1'b0;
      addr_error <= 1'b0;
    end else if (cpu_commit) begin
      collision  <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      if (eq.eq_frame_start && load_active) begin
        collision <= 1'b1;
      end
      if (set_addr_error) begin
        addr_error <= 1'b1;
      end
    end
  end

  assign eq.eq_wr       = wr_en;
  assign eq.eq_wr_rst   = wr_rst;
  assign eq.eq_gain_lsb = gain_lsb;
  assign eq.eq_gain_msb = gain_msb;

endmodule
`default_nettype wire
